// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction-fetch responder with wait states, abort and a program-load port.
// Define INST_MEM_STATS_EN to add the stat_served / stat_aborted counters.
module inst_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        req_abort,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    output logic        busy,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
`ifdef INST_MEM_STATS_EN
    ,
    output logic [15:0] stat_served,
    output logic [15:0] stat_aborted
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d, rsp_data_q, rsp_data_d, rsp_addr_q, rsp_addr_d;
    logic        rsp_err_q, rsp_err_d;
    logic        accept, rd_oor, ld_oor;
    logic [31:0] rd_addr;
    logic [31:0] mem [2**ADDR_W];
    logic        unused_ld_lsb;

    assign unused_ld_lsb = ^ld_addr[1:0];
    assign ld_oor = |ld_addr[31:ADDR_W+2];

    always_comb begin
        req_ready = (state_q != WAIT) || req_abort;
        accept = req_valid && req_ready;
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        if (accept) begin
            addr_d = req_addr;
            cnt_d = WC;
            state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else if (req_abort) begin
            state_d = IDLE;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RESP : WAIT;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        // With zero wait states the read is sampled on the accepting edge itself.
        rd_addr = accept ? req_addr : addr_q;
        rd_oor = |rd_addr[31:ADDR_W+2];
        rsp_data_d = rsp_data_q;
        rsp_addr_d = rsp_addr_q;
        rsp_err_d = rsp_err_q;
        if (state_d == RESP) begin
            rsp_data_d = rd_oor ? '0 : mem[rd_addr[ADDR_W+1:2]];
            rsp_addr_d = rd_addr;
            rsp_err_d = rd_oor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            addr_q <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Memory is deliberately not reset; the nonblocking write gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (ld_en && !ld_oor) mem[ld_addr[ADDR_W+1:2]] <= ld_data;
    end

    assign rsp_valid = state_q == RESP;
    assign busy = state_q == WAIT;
    assign rsp_data = rsp_data_q;
    assign rsp_addr = rsp_addr_q;
    assign rsp_err = rsp_err_q;

`ifdef INST_MEM_STATS_EN
    logic [15:0] served_q, served_d, aborted_q, aborted_d;

    always_comb begin
        served_d = served_q + 16'(state_d == RESP);
        aborted_d = aborted_q + 16'(req_abort && state_q == WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_q <= '0;
            aborted_q <= '0;
        end else begin
            served_q <= served_d;
            aborted_q <= aborted_d;
        end
    end

    assign stat_served = served_q;
    assign stat_aborted = aborted_q;
`endif
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: randomized and directed checks of inst_mem_responder against a transaction-level model.
module tb_inst_mem_responder;
    localparam int W = 2;
    localparam int AW = 10;

    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_abort = 1'b0, ld_en = 1'b0;
    logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;
    logic req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data, rsp_addr;
`ifdef INST_MEM_STATS_EN
    logic [15:0] stat_served, stat_aborted;
`endif

    inst_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_abort(req_abort), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err), .busy(busy),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef INST_MEM_STATS_EN
        , .stat_served(stat_served), .stat_aborted(stat_aborted)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, ncyc = 0;
    // Model: a pending request counts down edges to its sampling edge; memory is a plain array.
    logic [31:0] mem_m [1024];
    bit pend, resp_m, e_m, last_acc;
    logic [31:0] paddr, d_m, a_m;
    int left;
    logic [15:0] served_m, aborted_m;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, ncyc);
        end
    endtask

    function automatic bit oor(logic [31:0] a);
        return a[31:AW+2] != 0;
    endfunction

    task automatic model_reset();
        pend = 0; resp_m = 0; e_m = 0; d_m = 0; a_m = 0; left = 0;
        served_m = 0; aborted_m = 0; last_acc = 0;
    endtask

    task automatic check_out();
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, resp_m});
        chk("rsp_data", rsp_data, d_m);
        chk("rsp_addr", rsp_addr, a_m);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e_m});
        chk("busy", {31'b0, busy}, {31'b0, pend});
`ifdef INST_MEM_STATS_EN
        chk("stat_served", {16'b0, stat_served}, {16'b0, served_m});
        chk("stat_aborted", {16'b0, stat_aborted}, {16'b0, aborted_m});
`endif
    endtask

    // One clock: check what the last edge produced, drive new inputs, predict the next edge.
    task automatic cyc(input bit v, input logic [31:0] a, input bit ab,
                       input bit le, input logic [31:0] la, input logic [31:0] ld);
        bit acc;
        @(negedge clk);
        ncyc++;
        check_out();
        req_valid = v; req_addr = a; req_abort = ab; ld_en = le; ld_addr = la; ld_data = ld;
        #1;
        chk("req_ready", {31'b0, req_ready}, {31'b0, (!pend || ab)});
        acc = v && (!pend || ab);
        if (ab && pend) aborted_m++;
        if (acc) begin
            pend = 1; paddr = a; left = W;
        end else if (ab) pend = 0;
        resp_m = 0;
        if (pend) begin
            if (left == 0) begin
                resp_m = 1; served_m++; pend = 0;
                e_m = oor(paddr);
                d_m = e_m ? 32'h0 : mem_m[paddr[AW+1:2]];
                a_m = paddr;
            end else left--;
        end
        if (le && !oor(la)) mem_m[la[AW+1:2]] = ld;
        last_acc = acc;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Waits for the next response; returns the number of idle cycles spent.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 10) begin
            idle();
            n++;
        end
        if (!rsp_valid) chk("rsp timeout", 0, 1);
    endtask

    function automatic logic [31:0] raddr();
        int r = $urandom_range(0, 9);
        if (r < 8) return 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        if (r == 8) return 32'((32'h1000 << $urandom_range(0, 19)) | $urandom_range(0, 4095));
        return 32'h104;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, i, k;
        int t[$];
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset req_ready", {31'b0, req_ready}, 1);
        rst = 1'b0;

        for (int j = 0; j < 16; j++)
            cyc(0, 0, 0, 1, 32'(j * 4), j == 0 ? 32'h8001060A : j == 2 ? 32'h11112222 : $urandom);
        cyc(0, 0, 0, 1, 32'h104, 32'hCAFE0104);

        // Single read: response observed on the third cycle after the request is driven.
        cyc(1, 0, 0, 0, 0, 0);
        wait_rsp(n);
        chk("latency", n, 3);
        chk("read0 data", rsp_data, 32'h8001060A);
        chk("read0 err", {31'b0, rsp_err}, 0);
        idle();

        // Back-to-back stream 0,4,8 with valid held.
        i = 0;
        k = 0;
        while (t.size() < 3 && k < 30) begin
            cyc(i < 3, 32'(i * 4), 0, 0, 0, 0);
            if (last_acc) i++;
            if (rsp_valid) t.push_back(ncyc);
            k++;
        end
        chk("b2b count", t.size(), 3);
        if (t.size() == 3) begin
            chk("b2b gap1", t[1] - t[0], 3);
            chk("b2b gap2", t[2] - t[1], 3);
        end
        idle();
        idle();

        // Abort with simultaneous branch-target request.
        cyc(1, 4, 0, 0, 0, 0);
        cyc(1, 32'h104, 1, 0, 0, 0);
        wait_rsp(n);
        chk("abort latency", n, 3);
        chk("abort rsp_addr", rsp_addr, 32'h104);
        chk("abort rsp_data", rsp_data, 32'hCAFE0104);
        idle();

        // Out of range read, then ignored out-of-range load.
        cyc(1, 32'h1000, 0, 0, 0, 0);
        wait_rsp(n);
        chk("oor err", {31'b0, rsp_err}, 1);
        chk("oor data", rsp_data, 0);
        cyc(0, 0, 0, 1, 32'h1000, 32'h12345678);
        cyc(1, 0, 0, 0, 0, 0);
        wait_rsp(n);
        chk("oor load ignored", rsp_data, 32'h8001060A);

        // Collision: load on the sampling edge returns the old word.
        cyc(1, 8, 0, 0, 0, 0);
        idle();
        cyc(0, 0, 0, 1, 8, 32'hDEADBEEF);
        idle();
        chk("collision valid", {31'b0, rsp_valid}, 1);
        chk("collision old", rsp_data, 32'h11112222);
        cyc(1, 8, 0, 0, 0, 0);
        wait_rsp(n);
        chk("collision reread", rsp_data, 32'hDEADBEEF);

        // Asynchronous reset during WAIT.
        cyc(1, 0, 0, 0, 0, 0);
        idle();
        chk("pre-reset busy", {31'b0, busy}, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst rsp_valid", {31'b0, rsp_valid}, 0);
        chk("arst busy", {31'b0, busy}, 0);
        chk("arst req_ready", {31'b0, req_ready}, 1);
        chk("arst rsp_data", rsp_data, 0);
        chk("arst rsp_addr", rsp_addr, 0);
`ifdef INST_MEM_STATS_EN
        chk("arst stat_served", {16'b0, stat_served}, 0);
        chk("arst stat_aborted", {16'b0, stat_aborted}, 0);
`endif
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) idle();

        // Randomized traffic.
        repeat (400) begin
            bit v = $urandom_range(0, 9) < 6;
            bit ab = $urandom_range(0, 99) < 8;
            bit le = $urandom_range(0, 9) < 2;
            cyc(v, raddr(), ab, le, raddr(), $urandom);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
